// File: rtl/series_arbiter.sv
// Round-robin front end that shares one start/ready series-evaluation engine
// between NREQ requesters, with a watchdog that aborts a hung engine job.
module series_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] x_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              err,
    output logic              busy,
    output logic              eng_start,
    output logic [W-1:0]      eng_x,
    input  logic              eng_ready,
    input  logic [W-1:0]      eng_result
);

    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            err_q, err_d;
    logic            eng_start_q, eng_start_d;
    logic [W-1:0]    eng_x_q, eng_x_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic            found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [WDW-1:0]  wd_inc;
    logic            wd_expired;

    // Rotating-priority search starting at ptr_q; first hit wins.
    // NOTE: every variable written in an always_comb gets a default before any
    // branch, otherwise the paths that skip it infer a latch.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign wd_inc     = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    assign wd_expired = (wd_q >= WD_LAST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        gnt_d       = '0;
        done_d      = '0;
        result_d    = result_q;
        err_d       = err_q;
        eng_start_d = 1'b0;
        eng_x_d     = eng_x_q;
        wd_d        = wd_q;

        unique case (state_q)
            IDLE: begin
                if (eng_ready && found) begin
                    idx_d   = win_idx;
                    eng_x_d = x_in[int'(win_idx)*W +: W];
                    gnt_d   = NREQ'(1) << win_idx;
                    state_d = START;
                end
            end
            START: begin
                eng_start_d = 1'b1;
                wd_d        = '0;
                state_d     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                wd_d = wd_inc;
                if (!eng_ready) begin
                    state_d = WAIT_DONE;
                end else if (wd_expired) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = NREQ'(1) << idx_q;
                    state_d  = RESP;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_inc;
                // A completion seen on the expiry cycle still counts as success.
                if (eng_ready) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    done_d   = NREQ'(1) << idx_q;
                    state_d  = RESP;
                end else if (wd_expired) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = NREQ'(1) << idx_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            eng_start_q <= 1'b0;
            eng_x_q     <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            err_q       <= err_d;
            eng_start_q <= eng_start_d;
            eng_x_q     <= eng_x_d;
            wd_q        <= wd_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;

endmodule

// File: tb/tb_series_arbiter.sv
// Directed bench for series_arbiter: a behavioural engine with programmable
// busy time, plus hand-computed grant orders, latencies and results.
module tb_series_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 16;
    localparam int BUDGET  = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] x_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      result;
    logic              err;
    logic              busy;
    logic              eng_start;
    logic [W-1:0]      eng_x;
    logic              eng_ready;
    logic [W-1:0]      eng_result;

    series_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .x_in       (x_in),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_ready  (eng_ready),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    // Engine model: ready drops on the edge that sees start and stays low for
    // busy_cycles cycles; eng_hang makes it ignore start entirely.
    logic       model_ready = 1'b1;
    logic       force_busy  = 1'b0;
    logic       eng_hang    = 1'b0;
    int         busy_cycles = 2;
    int         eng_cnt     = 0;
    logic [7:0] eng_res_val = '0;

    assign eng_ready  = model_ready && !force_busy;
    assign eng_result = eng_res_val;

    always @(posedge clk) begin
        if (eng_start && !eng_hang) begin
            model_ready <= 1'b0;
            eng_cnt     <= busy_cycles;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) model_ready <= 1'b1;
        end
    end

    int   viol = 0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (eng_start && prev_start) viol++;
            if ($countones(gnt) > 1 || $countones(done) > 1) viol++;
        end
        prev_start = eng_start;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g);
        int n;
        n = 0;
        while (gnt === '0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        g = gnt;
    endtask

    // Returns the number of cycles from the calling (gnt) cycle to done.
    task automatic wait_done(output logic [NREQ-1:0] d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done === '0 && n < BUDGET);
        d = done;
    endtask

    logic [NREQ-1:0] g, d;
    int              n, starts, extra, bad;
    logic [3:0]      rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {gnt, done, result, err, busy, eng_start, eng_x}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_not_busy", busy, 0);

        // Round-robin with all four requesting, pointer starting at 0.
        busy_cycles = 2;
        eng_res_val = 8'h10;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g);
            check($sformatf("rr_gnt%0d", i), g, rr_exp[i]);
            if (i == 4) req = '0;
            wait_done(d, n);
            check($sformatf("rr_done%0d", i), d, rr_exp[i]);
            check($sformatf("rr_lat%0d", i), n, 5);
        end

        // Pointer is now 1; req[3] raised while requester 0 is being served.
        req = 4'b0001;
        wait_gnt(g);
        check("starve_gnt0", g, 4'b0001);
        req = 4'b1001;
        wait_done(d, n);
        wait_gnt(g);
        check("starve_gnt3", g, 4'b1000);
        req = 4'b0001;
        wait_done(d, n);
        wait_gnt(g);
        check("starve_gnt0_again", g, 4'b0001);
        req = '0;
        wait_done(d, n);

        // Single request, 10-cycle engine job.
        busy_cycles = 10;
        eng_res_val = 8'h2A;
        x_in = 32'h44_33_05_11;
        req = 4'b0010;
        wait_gnt(g);
        check("single_gnt", g, 4'b0010);
        req = '0;
        n = 0; starts = 0; extra = 0;
        do begin
            @(negedge clk);
            n++;
            starts += int'(eng_start);
            if (gnt !== '0) extra++;
        end while (done === '0 && n < BUDGET);
        check("single_done", done, 4'b0010);
        check("single_latency", n, 13);
        check("single_starts", starts, 1);
        check("single_extra_gnt", extra, 0);
        check("single_eng_x", eng_x, 8'h05);
        check("single_result", result, 8'h2A);
        check("single_err", err, 0);
        @(negedge clk);
        check("single_idle", {busy, done}, 5'b0);
        check("single_result_held", result, 8'h2A);

        // Hung engine: watchdog abort TIMEOUT cycles after eng_start.
        eng_hang = 1'b1;
        req = 4'b0100;
        wait_gnt(g);
        check("to_gnt", g, 4'b0100);
        req = '0;
        wait_done(d, n);
        check("to_done", d, 4'b0100);
        check("to_latency", n - 1, TIMEOUT);
        check("to_err", err, 1);
        check("to_result", result, 8'h00);
        eng_hang = 1'b0;

        busy_cycles = 3;
        eng_res_val = 8'h5C;
        req = 4'b1000;
        wait_gnt(g);
        check("post_to_gnt", g, 4'b1000);
        req = '0;
        wait_done(d, n);
        check("post_to_done", d, 4'b1000);
        check("post_to_latency", n, 6);
        check("post_to_err", {err, result}, {1'b0, 8'h5C});

        // Completion on the watchdog's last cycle still succeeds.
        busy_cycles = TIMEOUT - 2;
        eng_res_val = 8'h3C;
        req = 4'b0001;
        wait_gnt(g);
        check("tie_gnt", g, 4'b0001);
        req = '0;
        wait_done(d, n);
        check("tie_latency", n, TIMEOUT + 1);
        check("tie_result", {err, result}, {1'b0, 8'h3C});

        // One cycle slower: aborted.
        busy_cycles = TIMEOUT - 1;
        eng_res_val = 8'h7E;
        req = 4'b0001;
        wait_gnt(g);
        check("late_gnt", g, 4'b0001);
        req = '0;
        wait_done(d, n);
        check("late_latency", n, TIMEOUT + 1);
        check("late_result", {err, result}, {1'b1, 8'h00});
        repeat (3) @(negedge clk);

        // Operand must stay latched after x_in changes and req drops.
        busy_cycles = 4;
        eng_res_val = 8'h11;
        x_in = 32'h00_77_00_00;
        req = 4'b0100;
        wait_gnt(g);
        check("stab_gnt", g, 4'b0100);
        x_in = '1;
        req = '0;
        n = 0; bad = 0; extra = 0;
        do begin
            @(negedge clk);
            n++;
            if (eng_x !== 8'h77) bad++;
            if (gnt !== '0) extra++;
        end while (done === '0 && n < BUDGET);
        check("stab_done", done, 4'b0100);
        check("stab_latency", n, 7);
        check("stab_eng_x_changes", bad, 0);
        check("stab_extra_gnt", extra, 0);

        // Reset while the engine is busy; pointer was 3 before the reset.
        busy_cycles = 20;
        eng_res_val = 8'h99;
        x_in = 32'hAB_CD_EF_12;
        req = 4'b1000;
        wait_gnt(g);
        check("rst_pre_gnt", g, 4'b1000);
        req = '0;
        repeat (6) @(negedge clk);
        check("rst_pre_busy", busy, 1);
        #2 rst = 1'b0;
        #1 check("rst_mid_outputs", {gnt, done, result, err, busy, eng_start, eng_x}, 32'h0);
        force_busy = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (gnt !== '0) extra++;
        end
        check("rst_no_gnt_while_busy", extra, 0);
        busy_cycles = 2;
        eng_res_val = 8'h42;
        force_busy = 1'b0;
        wait_gnt(g);
        // Stale pointer 3 would pick requester 3 here.
        check("rst_ptr_restart", g, 4'b0001);
        check("rst_eng_x", eng_x, 8'h12);
        req = '0;
        wait_done(d, n);
        check("rst_done", d, 4'b0001);
        check("rst_result", {err, result}, {1'b0, 8'h42});

        check("pulse_monitor", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
